uart_tx: RTL and testbench

Serial UART transmitter: accepts one byte per handshake and shifts it out as an 8N1 frame by default (start bit, 8 data bits LSB first, optional parity, stop bit(s)). Paced by the shared oversampling baud tick `b_tick`, the same tick that drives the UART receiver, so TX and RX run at one baud rate. Sits between the TX FIFO read side and the `tx` pad in the uart_fifo subsystem. Its line output loops back cleanly into the existing receiver.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one accepted byte as start, 8 data bits (LSB first),
// optional parity and 1-2 stop bits, paced by the shared oversampling baud tick.
module uart_tx #(
    parameter int unsigned OVERSAMPLE = 32'd8,
    parameter int unsigned PARITY     = 32'd0,
    parameter int unsigned STOP_BITS  = 32'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic       start_trigger,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 32'd1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 32'd1);

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] tick_r, tick_s;
    logic [2:0] bit_r, bit_s;
    logic [7:0] shift_r, shift_s;
    logic       par_r, par_s;
    logic       tx_r, tx_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       bit_end_s;

    // Next-state, counter, shift and registered-output computation
    always_comb begin
        state_s   = state_r;
        tick_s    = tick_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        par_s     = par_r;
        done_s    = 1'b0;
        bit_end_s = b_tick && (tick_r == TICK_LAST);

        if (state_r != S_IDLE && b_tick) begin
            tick_s = bit_end_s ? 4'd0 : tick_r + 4'd1;
        end else begin
            tick_s = tick_r;
        end

        case (state_r)
            S_IDLE: begin
                if (start_trigger) begin
                    shift_s = tx_data;
                    par_s   = parity_of(tx_data, PARITY == 32'd2);
                    tick_s  = 4'd0;
                    bit_s   = 3'd0;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[7:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = (PARITY != 32'd0) ? S_PARITY : S_STOP;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    bit_s   = 3'd0;
                    state_s = S_STOP;
                end else begin
                    state_s = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (bit_r == STOP_LAST) begin
                        bit_s   = 3'd0;
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        state_s = S_STOP;
                    end
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays registered
        case (state_s)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
            S_PARITY: tx_s = par_s;
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            tick_r  <= 4'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx over several parameter sets: stimulus queues bytes,
// a per-instance line monitor rebuilds the expected frame and checks it tick by tick.
module tb_uart_tx;

    logic clk;
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int blk, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, blk, act, exp, $time);
        end
    endtask

    // Reference frame: list of line levels, one per bit period
    function automatic int frame_bits(input logic [7:0] d, input int par, input int sb,
                                      output logic [11:0] b);
        int n;
        int ones;
        b    = '1;
        n    = 0;
        ones = $countones(d);
        b[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i];
            n++;
        end
        if (par != 0) begin
            b[n] = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            b[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    function automatic int cfg_os(input int g);
        case (g)
            3:       return 16;
            4:       return 4;
            default: return 8;
        endcase
    endfunction
    function automatic int cfg_par(input int g);
        case (g)
            1:       return 1;
            2:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_sb(input int g);
        return (g >= 3) ? 2 : 1;
    endfunction
    function automatic int cfg_div(input int g);
        case (g)
            2:       return 3;
            3:       return 1;
            4:       return 2;
            default: return 4;
        endcase
    endfunction

    genvar g;
    for (g = 0; g < 5; g++) begin : cfg
        localparam int OS  = cfg_os(g);
        localparam int PAR = cfg_par(g);
        localparam int SB  = cfg_sb(g);
        localparam int DIV = cfg_div(g);

        logic       rst, b_tick, start_trigger, tx, tx_busy, tx_done;
        logic [7:0] tx_data;
        logic [7:0] q[$];
        int         pushed = 0;
        int         aborted = 0;
        int         dones_seen = 0;
        bit         finished = 1'b0;

        uart_tx #(.OVERSAMPLE(OS), .PARITY(PAR), .STOP_BITS(SB)) dut (
            .clk(clk), .rst(rst), .b_tick(b_tick), .start_trigger(start_trigger),
            .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
        );

        initial begin
            int c;
            c = $urandom_range(DIV - 1, 0);
            b_tick <= 1'b0;
            forever begin
                @(posedge clk);
                c = (c + 1) % DIV;
                b_tick <= (c == 0);
            end
        end

        // Monitor: ticks seen at the falling edge are the ones the DUT consumes next
        initial begin
            bit          in_frame = 1'b0;
            bit          want_done = 1'b0;
            bit          rst_prev = 1'b0;
            int          tcount = 0;
            int          nbits = 0;
            logic [11:0] bits = '1;
            forever begin
                @(negedge clk);
                if (rst_prev)
                    check("reset_state", g, {tx, tx_busy, tx_done}, 3'b100);
                if (tx_done === 1'b1) dones_seen++;
                if (rst) begin
                    in_frame  = 1'b0;
                    want_done = 1'b0;
                end else if (want_done) begin
                    check("frame_end", g, {tx, tx_busy, tx_done}, 3'b101);
                    want_done = 1'b0;
                end else begin
                    if (!in_frame && tx_busy === 1'b1) begin
                        check("frame_expected", g, (q.size() > 0), 1);
                        if (q.size() > 0) nbits = frame_bits(q.pop_front(), PAR, SB, bits);
                        else nbits = frame_bits(8'hxx, PAR, SB, bits);
                        in_frame = 1'b1;
                        tcount   = 0;
                    end
                    if (in_frame && b_tick) begin
                        check("line_bit", g, {tx, tx_busy, tx_done},
                              {bits[tcount / OS], 1'b1, 1'b0});
                        tcount++;
                        if (tcount == nbits * OS) begin
                            in_frame  = 1'b0;
                            want_done = 1'b1;
                        end
                    end
                end
                rst_prev = rst;
            end
        end

        task automatic wait_idle();
            int budget = 0;
            @(posedge clk); #1;
            while (tx_busy !== 1'b0 && budget < 20000) begin
                @(posedge clk); #1;
                budget++;
            end
            check("idle_wait", g, tx_busy, 0);
        endtask

        task automatic wait_done();
            int budget = 0;
            @(posedge clk); #1;
            while (tx_done !== 1'b1 && budget < 20000) begin
                @(posedge clk); #1;
                budget++;
            end
            check("done_wait", g, tx_done, 1);
        endtask

        task automatic send(input logic [7:0] b);
            wait_idle();
            start_trigger = 1'b1;
            tx_data       = b;
            q.push_back(b);
            pushed++;
            @(posedge clk); #1;
            start_trigger = 1'b0;
            tx_data       = 8'($urandom);
        endtask

        initial begin
            logic [7:0] directed[4];
            directed      = '{8'h55, 8'h07, 8'h03, 8'h80};
            rst           = 1'b1;
            start_trigger = 1'b0;
            tx_data       = 8'h00;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            foreach (directed[i]) send(directed[i]);

            // A request while busy must be dropped, not queued
            send(8'h0F);
            repeat (OS * DIV * 2) @(posedge clk);
            #1;
            start_trigger = 1'b1;
            tx_data       = 8'hAA;
            repeat (5) @(posedge clk);
            #1 start_trigger = 1'b0;

            // Abort in the middle of data bit 3, then resume
            send(8'($urandom));
            repeat (4 * OS * DIV + (OS * DIV) / 2) @(posedge clk);
            #1 rst = 1'b1;
            aborted++;
            @(posedge clk);
            #1 rst = 1'b0;
            send(8'hC3);

            // Back-to-back frames with the request held high
            wait_idle();
            start_trigger = 1'b1;
            tx_data       = 8'h00;
            q.push_back(8'h00);
            pushed++;
            wait_done();
            tx_data = 8'hFF;
            q.push_back(8'hFF);
            pushed++;
            wait_done();
            tx_data = 8'hA5;
            q.push_back(8'hA5);
            pushed++;
            wait_done();
            start_trigger = 1'b0;

            for (int k = 0; k < 16; k++) begin
                repeat ($urandom_range(10, 0)) @(posedge clk);
                send(8'($urandom));
            end

            wait_idle();
            repeat (OS * DIV * 4) @(posedge clk);
            check("done_count", g, dones_seen, pushed - aborted);
            check("queue_empty", g, q.size(), 0);
            finished = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(cfg[0].finished && cfg[1].finished && cfg[2].finished &&
                 cfg[3].finished && cfg[4].finished) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        check("all_finished", 99,
              {cfg[0].finished, cfg[1].finished, cfg[2].finished, cfg[3].finished,
               cfg[4].finished}, 5'h1F);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
